inner_dot_sched: RTL and testbench
==================================

// Module: inner_dot_sched
// PURPOSE
//   Sequencer for the shared 9-tap inner-dot datapath (conv/FC operand mux + inner_dot_T2_utility).
//   One job = CONV_STEPS conv issues (cnt 0..CONV_STEPS-1), then one FC issue (cnt = CONV_STEPS).
//   Drives the mux select counter and in_vld, and tracks results through the datapath pipeline.
//   Reports result valid with index and FC flag, then a done pulse. Sits between the layer FSM and the dot unit.
// PARAMETERS
//   CONV_STEPS  67  conv issues per job; the FC issue uses cnt = CONV_STEPS (mux select condition)
//   LAT         2   in_vld-to-ans latency of the dot datapath in cycles, >= 1
//   CNT_W       7   cnt width = $clog2(CONV_STEPS+2)
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      synchronous active-low reset
//   start      in   1      job request; accepted only in IDLE
//   src_rdy    in   1      operand buffers hold valid data for the current cnt
//   cnt        out  CNT_W  mux select / operand index to the dot unit
//   in_vld     out  1      issue strobe to the dot unit
//   busy       out  1      high in every state except IDLE
//   dot_vld    out  1      dot unit output is valid this cycle
//   dot_idx    out  CNT_W  cnt value of the issue producing the current result
//   dot_is_fc  out  1      current result is the FC issue (dot_idx == CONV_STEPS)
//   done       out  1      one-cycle pulse after the last result retires
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge): state=IDLE, cnt=0, tracking pipe cleared.
//     in_vld, busy, dot_vld, dot_is_fc and done are 0. dot_idx = 0.
//   FSM states: IDLE, CONV, FC, DRAIN, DONE. cnt, state and pipe are registered.
//   in_vld = src_rdy & (state==CONV | state==FC). It is combinational and is the only stall mechanism.
//   IDLE: cnt=0. start=1 -> CONV on the next cycle. start in any other state is ignored, with no queuing.
//   CONV: on in_vld, cnt <= cnt+1. The issue at cnt==CONV_STEPS-1 moves to FC with cnt=CONV_STEPS.
//     src_rdy=0 holds cnt and state.
//   FC: on in_vld, cnt <= CONV_STEPS+1 and state -> DRAIN. src_rdy=0 holds.
//   DRAIN: in_vld forced 0, cnt held at CONV_STEPS+1. Wait until the tracking pipe is empty -> DONE.
//   DONE: done=1 for exactly one cycle, then IDLE with cnt=0.
//     A start asserted while in DONE is ignored.
//   Tracking pipe: LAT-deep shift register of {vld, idx}, loaded each cycle with {in_vld, cnt}.
//     dot_vld/dot_idx are the stage-LAT outputs and are aligned with the dot unit's ans.
//     dot_is_fc = dot_vld & (dot_idx == CONV_STEPS).
//     When dot_vld=0, dot_idx holds its last value and must not be used.
//   Ordering: results retire in issue order. Exactly CONV_STEPS+1 dot_vld pulses per job.
//     The last of these (FC) precedes done by >= 1 cycle.
//   Bubbles: src_rdy gaps propagate as dot_vld=0 gaps of equal length, LAT cycles later.
//   cnt never exceeds CONV_STEPS+1 and never wraps. The value CONV_STEPS appears only in FC.
//   Reset mid-job: synchronous abort to IDLE. In-flight results are discarded: dot_vld=0 from the next cycle, no done.
//   Minimum job length with src_rdy=1 throughout: 1 (IDLE->CONV) + CONV_STEPS + 1 + LAT + 1 (DONE) cycles from the start edge.
// TESTING
//   T1 reset: rst_n=0 for 2 cycles with start=1 -> all outputs 0, state stays IDLE.
//   T2 full job, src_rdy=1, defaults: start pulse -> in_vld high 68 cycles with cnt 0..67.
//     Then 68 dot_vld pulses, idx 0..67; dot_is_fc only at idx 67; done 1 cycle after the idx-67 result.
//   T3 stall: src_rdy=0 for 3 cycles at cnt=10 and for 2 cycles in FC.
//     -> cnt holds at 10 and at 67; dot_vld gaps of 3 and 2 cycles; total result count still 68.
//   T4 start while busy: start at cnt=30 and again in DONE -> ignored, a single done.
//     A start 1 cycle after done launches a new job from cnt=0.
//   T5 reset mid-job at cnt=40 with 2 results in flight -> next cycle IDLE, cnt=0, dot_vld=0, no done.
//     A following start runs a clean job.
//   T6 params CONV_STEPS=3, LAT=1: cnt sequence 0,1,2,3 then 4 in DRAIN.
//     dot_is_fc at idx 3; done follows 1 cycle after the last dot_vld.

Source files
------------

// File: rtl/inner_dot_sched.sv
// inner_dot_sched: issue sequencer for the shared 9-tap inner-dot datapath.
// Steps the operand mux (cnt) through CONV_STEPS conv issues and one FC
// issue, strobes in_vld, and tracks issues through the dot pipeline.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               job request, taken only when idle
//   src_rdy             operands valid for the current cnt
//   cnt, in_vld         mux select / issue strobe to the dot unit
//   busy                high whenever a job is in progress
//   dot_vld, dot_idx    result valid and the cnt that produced it
//   dot_is_fc           current result is the FC issue
//   done                one-cycle pulse after the last result retires
module inner_dot_sched #(
  parameter int CONV_STEPS = 67,
  parameter int LAT        = 2,
  parameter int CNT_W      = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             src_rdy,
  output logic [CNT_W-1:0] cnt,
  output logic             in_vld,
  output logic             busy,
  output logic             dot_vld,
  output logic [CNT_W-1:0] dot_idx,
  output logic             dot_is_fc,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_FC,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CONV = CNT_W'(CONV_STEPS - 1);
  localparam logic [CNT_W-1:0] FC_IDX    = CNT_W'(CONV_STEPS);
  localparam logic [CNT_W-1:0] DRAIN_IDX = CNT_W'(CONV_STEPS + 1);

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [LAT-1:0]              vld_q, vld_d;
  logic [LAT-1:0][CNT_W-1:0]   idx_q, idx_d;
  logic                        upstream_vld;

  assign in_vld = src_rdy &
                  ((state_q == S_CONV) | (state_q == S_FC));

  // Tracking pipe. An index only advances together with a valid bit,
  // so dot_idx keeps the last retired value across bubbles.
  always_comb begin
    vld_d    = '0;
    idx_d    = idx_q;
    vld_d[0] = in_vld;
    if (in_vld) idx_d[0] = cnt_q;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      if (vld_q[i-1]) idx_d[i] = idx_q[i-1];
    end
  end

  // Anything still in flight ahead of the output stage. Leaving DRAIN
  // once only the output stage can be valid puts done on the cycle
  // right after the FC result.
  always_comb begin
    upstream_vld = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      upstream_vld = upstream_vld | vld_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) state_d = S_CONV;
      end
      S_CONV: begin
        if (in_vld) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CONV) state_d = S_FC;
        end
      end
      S_FC: begin
        if (in_vld) begin
          cnt_d   = DRAIN_IDX;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!upstream_vld) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      vld_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      idx_q   <= idx_d;
    end
  end

  assign cnt       = cnt_q;
  assign busy      = (state_q != S_IDLE);
  assign dot_vld   = vld_q[LAT-1];
  assign dot_idx   = idx_q[LAT-1];
  assign dot_is_fc = dot_vld & (dot_idx == FC_IDX);

endmodule

// File: tb/tb_inner_dot_sched.sv
// Bench for inner_dot_sched: default and small (3 steps, LAT 1) instances
// checked every cycle against a job-level model, plus directed sequences.
module tb_inner_dot_sched;

  localparam int CS0 = 67;
  localparam int LT0 = 2;
  localparam int W0  = 7;
  localparam int CS1 = 3;
  localparam int LT1 = 1;
  localparam int W1  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] start;
  logic [1:0] rdy;

  logic [W0-1:0] cnt0, idx0;
  logic          iv0, busy0, dv0, fc0, done0;
  logic [W1-1:0] cnt1, idx1;
  logic          iv1, busy1, dv1, fc1, done1;

  inner_dot_sched #(
    .CONV_STEPS(CS0), .LAT(LT0), .CNT_W(W0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .start(start[0]), .src_rdy(rdy[0]),
    .cnt(cnt0), .in_vld(iv0), .busy(busy0),
    .dot_vld(dv0), .dot_idx(idx0),
    .dot_is_fc(fc0), .done(done0)
  );

  inner_dot_sched #(
    .CONV_STEPS(CS1), .LAT(LT1), .CNT_W(W1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .start(start[1]), .src_rdy(rdy[1]),
    .cnt(cnt1), .in_vld(iv1), .busy(busy1),
    .dot_vld(dv1), .dot_idx(idx1),
    .dot_is_fc(fc1), .done(done1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm,
                     input int a, input int e);
    n_chk++;
    if (a == e) n_pass++;
    else $display("FAIL %s @%0t: got %0d, want %0d",
                  nm, $time, a, e);
  endtask

  // Job-level model: a job is "active", has issued k operands
  // (k = CS+1 once the FC issue is out), and each issue is
  // time-stamped and expected back LAT cycles later in order.
  typedef struct {int cyc; int idx;} iss_t;
  iss_t q0[$];
  iss_t q1[$];
  int   cs_p[2]  = '{CS0, CS1};
  int   lat_p[2] = '{LT0, LT1};
  bit   act[2];
  int   k[2];
  int   fc_cyc[2];
  int   cyc = 0;

  int n_iv[2], n_dv[2], n_fcr[2], n_done[2], n_gap[2];
  bit dv_seen[2];

  task automatic clr_tally();
    for (int i = 0; i < 2; i++) begin
      n_iv[i] = 0; n_dv[i] = 0; n_fcr[i] = 0;
      n_done[i] = 0; n_gap[i] = 0; dv_seen[i] = 0;
    end
  endtask

  function automatic bit m_done(input int i);
    return act[i] && k[i] > cs_p[i] &&
           cyc == fc_cyc[i] + lat_p[i] + 1;
  endfunction

  task automatic exp_of(input int i, output int e_cnt,
                        output int e_iv, output int e_busy);
    e_busy = act[i];
    e_iv   = 0;
    e_cnt  = 0;
    if (act[i] && k[i] <= cs_p[i]) begin
      e_cnt = k[i];
      e_iv  = rdy[i];
    end else if (act[i]) begin
      e_cnt = cs_p[i] + 1;
    end
  endtask

  task automatic check_inst(input int i);
    int o_cnt, o_iv, o_busy, o_dv, o_idx, o_fc, o_done;
    int e_cnt, e_iv, e_busy, ev, eidx;
    if (i == 0) begin
      o_cnt = int'(cnt0); o_iv = iv0; o_busy = busy0;
      o_dv = dv0; o_idx = int'(idx0); o_fc = fc0;
      o_done = done0;
    end else begin
      o_cnt = int'(cnt1); o_iv = iv1; o_busy = busy1;
      o_dv = dv1; o_idx = int'(idx1); o_fc = fc1;
      o_done = done1;
    end
    exp_of(i, e_cnt, e_iv, e_busy);
    ev = 0;
    eidx = 0;
    if (i == 0 && q0.size() > 0 &&
        q0[0].cyc == cyc - lat_p[0]) begin
      ev = 1; eidx = q0[0].idx; void'(q0.pop_front());
    end
    if (i == 1 && q1.size() > 0 &&
        q1[0].cyc == cyc - lat_p[1]) begin
      ev = 1; eidx = q1[0].idx; void'(q1.pop_front());
    end
    chk($sformatf("u%0d cnt", i), o_cnt, e_cnt);
    chk($sformatf("u%0d in_vld", i), o_iv, e_iv);
    chk($sformatf("u%0d busy", i), o_busy, e_busy);
    chk($sformatf("u%0d done", i), o_done, int'(m_done(i)));
    chk($sformatf("u%0d dot_vld", i), o_dv, ev);
    chk($sformatf("u%0d dot_is_fc", i), o_fc,
        int'(ev == 1 && eidx == cs_p[i]));
    if (ev == 1) chk($sformatf("u%0d dot_idx", i), o_idx, eidx);
    n_iv[i]   += o_iv;
    n_dv[i]   += o_dv;
    n_fcr[i]  += o_fc;
    n_done[i] += o_done;
    if (dv_seen[i] && !o_dv && !o_done) n_gap[i]++;
    if (o_dv) dv_seen[i] = 1;
  endtask

  task automatic update_inst(input int i);
    int e_cnt, e_iv, e_busy;
    bit dn;
    iss_t e;
    exp_of(i, e_cnt, e_iv, e_busy);
    dn = m_done(i);
    if (!rst_n) begin
      act[i] = 0;
      k[i]   = 0;
      if (i == 0) q0.delete(); else q1.delete();
    end else begin
      if (e_iv == 1) begin
        e.cyc = cyc;
        e.idx = e_cnt;
        if (i == 0) q0.push_back(e); else q1.push_back(e);
      end
      if (!act[i]) begin
        if (start[i]) begin act[i] = 1; k[i] = 0; end
      end else if (k[i] <= cs_p[i]) begin
        if (rdy[i]) begin
          if (k[i] == cs_p[i]) fc_cyc[i] = cyc;
          k[i]++;
        end
      end else if (dn) begin
        act[i] = 0;
      end
    end
  endtask

  // Inputs are set at the falling edge before calling step.
  task automatic step();
    #1;
    check_inst(0);
    check_inst(1);
    @(posedge clk);
    update_inst(0);
    update_inst(1);
    cyc++;
    @(negedge clk);
  endtask

  typedef struct {
    bit st; bit rd;
    int cnt; int iv; int busy; int dv;
    int idx; int fc; int done;
  } vec_t;
  vec_t tbl[11];

  int len, s10, sfc;

  initial begin
    //          st rd cnt iv by dv idx fc dn
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 1, 1, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 1, 1, 1, 1, 0, 0, 0};
    tbl[3]  = '{0, 0, 2, 0, 1, 1, 1, 0, 0};
    tbl[4]  = '{0, 1, 2, 1, 1, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 3, 0, 1, 1, 2, 0, 0};
    tbl[6]  = '{0, 1, 3, 1, 1, 0, 0, 0, 0};
    tbl[7]  = '{0, 1, 4, 0, 1, 1, 3, 1, 0};
    tbl[8]  = '{1, 1, 4, 0, 1, 0, 0, 0, 1};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

    // T1: reset held with start high
    rst_n = 1'b0;
    start = 2'b11;
    rdy   = 2'b11;
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;
    start = 2'b00;
    rdy   = 2'b00;
    step();

    // T2: full job, no stalls
    clr_tally();
    start[0] = 1; rdy[0] = 1;
    step();
    start[0] = 0;
    len = 1;
    while (n_done[0] == 0 && len < 400) begin
      step(); len++;
    end
    chk("T2 job_len", len, 1 + CS0 + 1 + LT0 + 1);
    chk("T2 issues", n_iv[0], CS0 + 1);
    chk("T2 results", n_dv[0], CS0 + 1);
    chk("T2 fc_results", n_fcr[0], 1);
    chk("T2 dones", n_done[0], 1);
    chk("T2 gaps", n_gap[0], 0);
    step();

    // T3: stalls of 3 at cnt 10 and 2 in FC
    clr_tally();
    start[0] = 1; rdy[0] = 1;
    step();
    start[0] = 0;
    len = 1; s10 = 0; sfc = 0;
    while (n_done[0] == 0 && len < 400) begin
      if (act[0] && k[0] == 10 && s10 < 3) begin
        rdy[0] = 0; s10++;
      end else if (act[0] && k[0] == CS0 && sfc < 2) begin
        rdy[0] = 0; sfc++;
      end else rdy[0] = 1;
      step(); len++;
    end
    chk("T3 job_len", len, 1 + CS0 + 1 + LT0 + 1 + 5);
    chk("T3 results", n_dv[0], CS0 + 1);
    chk("T3 gap_cycles", n_gap[0], 5);
    chk("T3 dones", n_done[0], 1);

    // T4: start while busy and in DONE, then restart
    clr_tally();
    start[0] = 1; rdy[0] = 1;
    step();
    len = 1;
    while (n_done[0] == 0 && len < 400) begin
      start[0] = (act[0] && k[0] == 30) || m_done(0);
      step(); len++;
    end
    start[0] = 0;
    chk("T4 dones", n_done[0], 1);
    chk("T4 idle_after", int'(busy0), 0);
    start[0] = 1;
    step();
    start[0] = 0;
    chk("T4 restart_cnt", int'(cnt0), 0);
    chk("T4 restart_busy", int'(busy0), 1);
    len = 0;
    while (n_done[0] < 2 && len < 800) begin
      rdy[0] = ($urandom_range(0, 3) != 0);
      step(); len++;
    end
    chk("T4 results", n_dv[0], 2 * (CS0 + 1));
    chk("T4 dones2", n_done[0], 2);

    // T5: reset mid-job with results in flight
    step();
    clr_tally();
    start[0] = 1; rdy[0] = 1;
    step();
    start[0] = 0;
    len = 0;
    while (!(act[0] && k[0] == 40) && len < 200) begin
      step(); len++;
    end
    chk("T5 inflight", int'(dv0), 1);
    rst_n = 0;
    step();
    rst_n = 1;
    #1;
    chk("T5 busy", int'(busy0), 0);
    chk("T5 cnt", int'(cnt0), 0);
    chk("T5 dot_vld", int'(dv0), 0);
    for (int i = 0; i < 6; i++) step();
    chk("T5 no_done", n_done[0], 0);
    clr_tally();
    start[0] = 1;
    step();
    start[0] = 0;
    len = 0;
    while (n_done[0] == 0 && len < 800) begin
      rdy[0] = ($urandom_range(0, 3) != 0);
      step(); len++;
    end
    chk("T5 clean_results", n_dv[0], CS0 + 1);
    chk("T5 clean_dones", n_done[0], 1);

    // T6: small instance, vector table
    rdy = 2'b00;
    for (int r = 0; r < 11; r++) begin
      start[1] = tbl[r].st;
      rdy[1]   = tbl[r].rd;
      #1;
      chk($sformatf("T6[%0d] cnt", r), int'(cnt1), tbl[r].cnt);
      chk($sformatf("T6[%0d] in_vld", r), int'(iv1), tbl[r].iv);
      chk($sformatf("T6[%0d] busy", r), int'(busy1), tbl[r].busy);
      chk($sformatf("T6[%0d] dot_vld", r), int'(dv1), tbl[r].dv);
      if (tbl[r].dv != 0)
        chk($sformatf("T6[%0d] dot_idx", r), int'(idx1), tbl[r].idx);
      chk($sformatf("T6[%0d] is_fc", r), int'(fc1), tbl[r].fc);
      chk($sformatf("T6[%0d] done", r), int'(done1), tbl[r].done);
      step();
    end

    // Random traffic on both instances against the model
    for (int c = 0; c < 2500; c++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      for (int i = 0; i < 2; i++) begin
        start[i] = ($urandom_range(0, 7) == 0);
        rdy[i]   = ($urandom_range(0, 3) != 0);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
